// File: rtl/riscstrong_pkg.sv
// Shared RV32I definitions: base opcodes, immediate formats and the default datapath width.
package riscstrong_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;

   typedef enum logic [2:0] {
      IMM_R,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: scatters the instruction's immediate bits into a sign-extended XLEN word.
module imm_gen
   import riscstrong_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:7]     instr,
   input  imm_fmt_t        fmt,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (fmt)
         IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
         IMM_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode / operand-fetch stage: decode, forwarding, load-use stall and the ID/EX register.
module id_stage
   import riscstrong_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_ready,
   output logic [4:0]      rf_read1,
   output logic [4:0]      rf_read2,
   input  logic [XLEN-1:0] rf_out1,
   input  logic [XLEN-1:0] rf_out2,
   input  logic            ex_ready,
   input  logic            flush,
   input  logic            ex_wr,
   input  logic [4:0]      ex_rd,
   input  logic            ex_is_load,
   input  logic [XLEN-1:0] ex_data,
   input  logic            mem_wr,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_rs1_val,
   output logic [XLEN-1:0] id_rs2_val,
   output logic [XLEN-1:0] id_imm,
   output logic [4:0]      id_rd,
   output logic [6:0]      id_opcode,
   output logic [2:0]      id_funct3,
   output logic            id_funct7b5,
   output logic            id_wr_reg,
   output logic            id_illegal
);

   logic [6:0]            opcode;
   logic [4:0]            rd;
   imm_fmt_t              fmt;
   logic                  illegal;
   logic                  writes_rd;
   logic                  use_rs1;
   logic                  use_rs2;
   logic [XLEN-1:0]       imm;
   logic [1:0][4:0]       rs_addr;
   logic [1:0][XLEN-1:0]  rf_val;
   logic [1:0][XLEN-1:0]  opnd;
   logic                  hazard;
   logic                  advance;

   logic                  valid_reg;
   logic [XLEN-1:0]       pc_reg;
   logic [XLEN-1:0]       rs1_val_reg;
   logic [XLEN-1:0]       rs2_val_reg;
   logic [XLEN-1:0]       imm_reg;
   logic [4:0]            rd_reg;
   logic [6:0]            opcode_reg;
   logic [2:0]            funct3_reg;
   logic                  funct7b5_reg;
   logic                  wr_reg_reg;
   logic                  illegal_reg;

   assign opcode     = if_instr[6:0];
   assign rd         = if_instr[11:7];
   assign rs_addr[0] = if_instr[19:15];
   assign rs_addr[1] = if_instr[24:20];
   assign rf_val[0]  = rf_out1;
   assign rf_val[1]  = rf_out2;
   assign rf_read1   = rs_addr[0];
   assign rf_read2   = rs_addr[1];

   always_comb begin
      fmt       = IMM_R;
      illegal   = 1'b0;
      writes_rd = 1'b0;
      use_rs1   = 1'b1;
      use_rs2   = 1'b0;
      case (opcode)
         OP:       begin writes_rd = 1'b1; use_rs2 = 1'b1; end
         OP_IMM:   begin writes_rd = 1'b1; fmt = IMM_I; end
         LOAD:     begin writes_rd = 1'b1; fmt = IMM_I; end
         STORE:    begin use_rs2 = 1'b1;   fmt = IMM_S; end
         BRANCH:   begin use_rs2 = 1'b1;   fmt = IMM_B; end
         JAL:      begin writes_rd = 1'b1; use_rs1 = 1'b0; fmt = IMM_J; end
         JALR:     begin writes_rd = 1'b1; fmt = IMM_I; end
         LUI:      begin writes_rd = 1'b1; use_rs1 = 1'b0; fmt = IMM_U; end
         AUIPC:    begin writes_rd = 1'b1; use_rs1 = 1'b0; fmt = IMM_U; end
         SYSTEM:   begin writes_rd = 1'b1; fmt = IMM_I; end
         MISC_MEM: fmt = IMM_I;
         default:  illegal = 1'b1;
      endcase
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (if_instr[31:7]),
      .fmt   (fmt),
      .imm   (imm)
   );

   // EX data is only usable when it is not a load; WB needs no bypass since the RF writes on negedge.
   for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      assign opnd[gi] = (rs_addr[gi] == 5'd0)                               ? '0       :
                        (ex_wr && ex_rd == rs_addr[gi] && !ex_is_load)      ? ex_data  :
                        (mem_wr && mem_rd == rs_addr[gi])                   ? mem_data :
                                                                              rf_val[gi];
   end

   assign hazard   = if_valid && ex_wr && ex_is_load && (ex_rd != 5'd0) &&
                     ((use_rs1 && ex_rd == rs_addr[0]) || (use_rs2 && ex_rd == rs_addr[1]));
   assign advance  = ex_ready || !valid_reg;
   assign id_ready = advance && !hazard;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg    <= 1'b0;
         pc_reg       <= RESET_PC;
         rs1_val_reg  <= '0;
         rs2_val_reg  <= '0;
         imm_reg      <= '0;
         rd_reg       <= '0;
         opcode_reg   <= '0;
         funct3_reg   <= '0;
         funct7b5_reg <= 1'b0;
         wr_reg_reg   <= 1'b0;
         illegal_reg  <= 1'b0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (advance) begin
         // A stalled instruction leaves a bubble and is decoded again next cycle.
         valid_reg    <= if_valid && !hazard;
         pc_reg       <= if_pc;
         rs1_val_reg  <= opnd[0];
         rs2_val_reg  <= opnd[1];
         imm_reg      <= imm;
         rd_reg       <= rd;
         opcode_reg   <= opcode;
         funct3_reg   <= if_instr[14:12];
         funct7b5_reg <= if_instr[30];
         wr_reg_reg   <= writes_rd && !illegal && (rd != 5'd0);
         illegal_reg  <= illegal;
      end
   end

   assign id_valid    = valid_reg;
   assign id_pc       = pc_reg;
   assign id_rs1_val  = rs1_val_reg;
   assign id_rs2_val  = rs2_val_reg;
   assign id_imm      = imm_reg;
   assign id_rd       = rd_reg;
   assign id_opcode   = opcode_reg;
   assign id_funct3   = funct3_reg;
   assign id_funct7b5 = funct7b5_reg;
   assign id_wr_reg   = wr_reg_reg;
   assign id_illegal  = illegal_reg;

endmodule
